// File: rtl/adc_i2c_sequencer_if.sv
// Command/response bus between the ADC sequencer (master) and the i2c byte engine (slave).
// Handshake: the master holds i2cInstruction/i2cByteToSend stable and raises i2cEnable.
// The slave raises i2cComplete when the step is done. The master then drops i2cEnable,
// and the slave drops i2cComplete before the next step can be issued.
interface adc_i2c_sequencer_if;
  logic [1:0] i2cInstruction;
  logic       i2cEnable;
  logic [7:0] i2cByteToSend;
  logic [7:0] i2cByteReceived;
  logic       i2cComplete;

  modport master (
    output i2cInstruction, i2cEnable, i2cByteToSend,
    input  i2cByteReceived, i2cComplete
  );

  modport slave (
    input  i2cInstruction, i2cEnable, i2cByteToSend,
    output i2cByteReceived, i2cComplete
  );
endinterface

// File: rtl/adc_i2c_sequencer.sv
// Single-shot ADS1115-class conversion sequencer: config write, conversion wait,
// pointer write, two-byte read. Repeats while adcEnable is held.
module adc_i2c_sequencer #(
  parameter logic [6:0]  DEV_ADDR  = 7'h48,
  parameter logic [2:0]  PGA       = 3'b001,
  parameter logic [7:0]  CFG_LO    = 8'h83,
  parameter logic [15:0] CONV_WAIT = 16'd2000,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adcEnable,
  input  logic [1:0]  adcChannel,
  output logic [15:0] adcOutputData,
  output logic        adcDataReady,
  output logic        adcBusy,
  output logic        adcError,
  output logic [2:0]  o_dbg_state,
  adc_i2c_sequencer_if.master i2c
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_ISSUE        = 3'd1;
  localparam logic [2:0] S_WAIT_DONE    = 3'd2;
  localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
  localparam logic [2:0] S_CONV_WAIT    = 3'd4;
  localparam logic [2:0] S_DONE         = 3'd5;

  localparam logic [1:0] I_START = 2'd0;
  localparam logic [1:0] I_STOP  = 2'd1;
  localparam logic [1:0] I_READ  = 2'd2;
  localparam logic [1:0] I_WRITE = 2'd3;

  logic [2:0]  r_state;
  logic [3:0]  r_step;
  logic [1:0]  r_chan;
  logic [7:0]  r_msb;
  logic [7:0]  r_lsb;
  logic [15:0] r_timer;
  logic [15:0] r_data;
  logic        r_ready;
  logic        r_busy;
  logic        r_error;
  logic [1:0]  r_instr;
  logic [7:0]  r_byte;
  logic        r_en;

  logic [1:0]  w_instr;
  logic [7:0]  w_byte;
  logic [7:0]  w_cfg_hi;

  // OS=1, MUX=1xx (single-ended), PGA, MODE=1 (single-shot)
  assign w_cfg_hi = {2'b11, r_chan, PGA, 1'b1};

  always_comb begin
    w_instr = I_START;
    w_byte  = 8'h00;
    case (r_step)
      4'd0, 4'd6, 4'd10: w_instr = I_START;
      4'd1, 4'd7: begin w_instr = I_WRITE; w_byte = {DEV_ADDR, 1'b0}; end
      4'd2:       begin w_instr = I_WRITE; w_byte = 8'h01;            end
      4'd3:       begin w_instr = I_WRITE; w_byte = w_cfg_hi;         end
      4'd4:       begin w_instr = I_WRITE; w_byte = CFG_LO;           end
      4'd5, 4'd9, 4'd14: w_instr = I_STOP;
      4'd8:       begin w_instr = I_WRITE; w_byte = 8'h00;            end
      4'd11:      begin w_instr = I_WRITE; w_byte = {DEV_ADDR, 1'b1}; end
      4'd12, 4'd13: w_instr = I_READ;
      default:    w_instr = I_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= 4'd0;
      r_chan  <= 2'd0;
      r_msb   <= 8'h00;
      r_lsb   <= 8'h00;
      r_timer <= 16'd0;
      r_data  <= 16'h0000;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
      r_instr <= 2'd0;
      r_byte  <= 8'h00;
      r_en    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (adcEnable) begin
            r_chan  <= adcChannel;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_step  <= 4'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_instr <= w_instr;
          r_byte  <= w_byte;
          r_en    <= 1'b1;
          r_timer <= 16'd0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i2c.i2cComplete) begin
            if (r_step == 4'd12) r_msb <= i2c.i2cByteReceived;
            if (r_step == 4'd13) r_lsb <= i2c.i2cByteReceived;
            r_en    <= 1'b0;
            r_state <= S_WAIT_RELEASE;
          end else if (r_timer == TIMEOUT - 16'd1) begin
            // Abort without STOP; the engine is assumed wedged.
            r_en    <= 1'b0;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_WAIT_RELEASE: begin
          if (!i2c.i2cComplete) begin
            if (r_step == 4'd5) begin
              r_timer <= 16'd0;
              r_state <= S_CONV_WAIT;
            end else if (r_step == 4'd14) begin
              r_data  <= {r_msb, r_lsb};
              r_ready <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_step  <= r_step + 4'd1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_CONV_WAIT: begin
          if (r_timer == CONV_WAIT - 16'd1) begin
            r_step  <= 4'd6;
            r_state <= S_ISSUE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adcOutputData      = r_data;
  assign adcDataReady       = r_ready;
  assign adcBusy            = r_busy;
  assign adcError           = r_error;
  assign o_dbg_state        = r_state;
  assign i2c.i2cInstruction = r_instr;
  assign i2c.i2cByteToSend  = r_byte;
  assign i2c.i2cEnable      = r_en;

endmodule

// File: tb/tb_adc_i2c_sequencer.sv
// Directed/randomized bench for adc_i2c_sequencer with a responding i2c engine model
// and a transaction-level reference of the expected instruction stream and results.
module tb_adc_i2c_sequencer;

  localparam int          CW   = 20;
  localparam int          TO   = 100;
  localparam logic [6:0]  DEV  = 7'h48;
  localparam logic [2:0]  PGA  = 3'b001;
  localparam logic [7:0]  CLO  = 8'h83;
  localparam logic [1:0]  START = 2'd0, STOP = 2'd1, READ = 2'd2, WRITE = 2'd3;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        adcEnable;
  logic [1:0]  adcChannel;
  logic [15:0] adcOutputData;
  logic        adcDataReady;
  logic        adcBusy;
  logic        adcError;
  logic [2:0]  dbg_state;

  adc_i2c_sequencer_if bus ();

  adc_i2c_sequencer #(
    .DEV_ADDR(DEV), .PGA(PGA), .CFG_LO(CLO),
    .CONV_WAIT(16'(CW)), .TIMEOUT(16'(TO))
  ) dut (
    .clk(clk), .rst(rst),
    .adcEnable(adcEnable), .adcChannel(adcChannel),
    .adcOutputData(adcOutputData), .adcDataReady(adcDataReady),
    .adcBusy(adcBusy), .adcError(adcError),
    .o_dbg_state(dbg_state),
    .i2c(bus)
  );

  typedef struct {
    logic [1:0] ins;
    logic [7:0] b;
    int         cyc;
    int         gap;
  } op_t;

  op_t         log_q[$];
  logic [7:0]  rd_q[$];
  logic [9:0]  exp_q[$];
  logic [15:0] res_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, cnt = 0, last_fall = 0, hang_op = -1;
  int ready_cnt = 0, adj_cnt = 0, err_cyc = 0;
  bit hang_cur = 0, prev_en = 0, prev_ready = 0, prev_err = 0;

  // engine model and output monitor, all on the falling edge
  always @(negedge clk) begin
    op_t e;
    cyc++;
    if (bus.i2cEnable && !prev_en) begin
      e.ins = bus.i2cInstruction;
      e.b   = bus.i2cByteToSend;
      e.cyc = cyc;
      e.gap = cyc - last_fall;
      log_q.push_back(e);
      hang_cur = ((log_q.size() - 1) == hang_op);
      cnt = 0;
      if (bus.i2cInstruction == READ)
        bus.i2cByteReceived = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
    end
    if (bus.i2cEnable && !bus.i2cComplete && !hang_cur) begin
      cnt++;
      if (cnt == 5) bus.i2cComplete = 1'b1;
    end
    if (!bus.i2cEnable && bus.i2cComplete) begin
      bus.i2cComplete = 1'b0;
      last_fall = cyc;
    end
    if (!bus.i2cEnable) cnt = 0;
    prev_en = bus.i2cEnable;
    if (adcDataReady) begin
      res_q.push_back(adcOutputData);
      ready_cnt++;
      if (prev_ready) adj_cnt++;
    end
    prev_ready = adcDataReady;
    if (adcError && !prev_err) err_cyc = cyc;
    prev_err = adcError;
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void build_txn(input logic [1:0] ch);
    logic [7:0] hi;
    hi = {2'b11, ch, PGA, 1'b1};
    exp_q.push_back({START, 8'h00});
    exp_q.push_back({WRITE, DEV, 1'b0});
    exp_q.push_back({WRITE, 8'h01});
    exp_q.push_back({WRITE, hi});
    exp_q.push_back({WRITE, CLO});
    exp_q.push_back({STOP,  8'h00});
    exp_q.push_back({START, 8'h00});
    exp_q.push_back({WRITE, DEV, 1'b0});
    exp_q.push_back({WRITE, 8'h00});
    exp_q.push_back({STOP,  8'h00});
    exp_q.push_back({START, 8'h00});
    exp_q.push_back({WRITE, DEV, 1'b1});
    exp_q.push_back({READ,  8'h00});
    exp_q.push_back({READ,  8'h00});
    exp_q.push_back({STOP,  8'h00});
  endfunction

  task automatic check_ops(input int base, input int n);
    logic [9:0] obs;
    for (int i = 0; i < n; i++) begin
      if (base + i < log_q.size()) obs = {log_q[base+i].ins, log_q[base+i].b};
      else obs = 10'h3FF;
      check($sformatf("op%0d", base + i), 32'(obs), 32'(exp_q.pop_front()));
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_enable();
    adcEnable = 1'b1;
    tick();
    adcEnable = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k;
    k = 0;
    while (log_q.size() < n && k < 2000) begin tick(); k++; end
    check({tag, "_wait"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int start, k;
    start = ready_cnt;
    k = 0;
    while (ready_cnt == start && k < 2000) begin tick(); k++; end
    check({tag, "_wait"}, 32'(ready_cnt > start), 32'd1);
  endtask

  task automatic push_reads(output logic [15:0] res);
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    rd_q.push_back(a);
    rd_q.push_back(b);
    res = {a, b};
  endtask

  initial begin
    int base, rc;
    logic [15:0] res, last_res;
    logic [15:0] exp_res[3];

    rst = 1'b1;
    adcEnable = 1'b0;
    adcChannel = 2'd0;
    bus.i2cComplete = 1'b0;
    bus.i2cByteReceived = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_data",  32'(adcOutputData), 32'h0);
    check("rst_ready", 32'(adcDataReady), 32'h0);
    check("rst_busy",  32'(adcBusy), 32'h0);
    check("rst_err",   32'(adcError), 32'h0);
    check("rst_en",    32'(bus.i2cEnable), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);

    // single conversion, channel 2, fixed read bytes
    base = log_q.size();
    rc = ready_cnt;
    adcChannel = 2'd2;
    rd_q.push_back(8'h12);
    rd_q.push_back(8'h34);
    pulse_enable();
    tick();
    check("t1_busy", 32'(adcBusy), 32'h1);
    wait_ready("t1");
    check("t1_result", 32'(adcOutputData), 32'h1234);
    repeat (30) tick();
    check("t1_ready_once", 32'(ready_cnt), 32'(rc + 1));
    check("t1_busy_off", 32'(adcBusy), 32'h0);
    check("t1_nops", 32'(log_q.size()), 32'(base + 15));
    build_txn(2'd2);
    check_ops(base, 15);
    check("t1_cfg_hi", 32'(log_q[base+3].b), 32'hE3);
    check("t2_conv_gap", 32'(log_q[base+6].gap), 32'(CW + 2));
    check("t2_plain_gap", 32'(log_q[base+10].gap), 32'd2);

    // continuous mode, channel change during run 1
    base = log_q.size();
    res_q.delete();
    for (int r = 0; r < 3; r++) begin
      push_reads(res);
      exp_res[r] = res;
    end
    adcChannel = 2'd1;
    adcEnable = 1'b1;
    wait_log(base + 1, "t3_first");
    adcChannel = 2'd3;
    for (int r = 0; r < 3; r++) wait_ready($sformatf("t3_run%0d", r));
    adcEnable = 1'b0;
    repeat (50) tick();
    check("t3_nres", 32'(res_q.size()), 32'd3);
    for (int r = 0; r < 3; r++)
      check($sformatf("t3_res%0d", r), 32'((r < res_q.size()) ? res_q[r] : 16'hxxxx), 32'(exp_res[r]));
    check("t3_not_adjacent", 32'(adj_cnt), 32'd0);
    check("t3_nops", 32'(log_q.size()), 32'(base + 45));
    build_txn(2'd1);
    build_txn(2'd3);
    build_txn(2'd3);
    check_ops(base, 45);
    check("t3_run2_cfg", 32'(log_q[base+18].b), 32'hF3);
    last_res = exp_res[2];

    // engine hangs on step 2
    base = log_q.size();
    hang_op = base + 2;
    adcChannel = 2'd0;
    pulse_enable();
    begin
      int k;
      k = 0;
      while (!adcError && k < 1000) begin tick(); k++; end
    end
    check("t4_err", 32'(adcError), 32'h1);
    check("t4_en", 32'(bus.i2cEnable), 32'h0);
    check("t4_busy", 32'(adcBusy), 32'h0);
    check("t4_data_kept", 32'(adcOutputData), 32'(last_res));
    check("t4_timeout_len", 32'(err_cyc - log_q[base+2].cyc), 32'(TO));
    repeat (20) tick();
    check("t4_no_stop", 32'(log_q.size()), 32'(base + 3));
    hang_op = -1;
    base = log_q.size();
    push_reads(res);
    pulse_enable();
    tick();
    check("t4_err_cleared", 32'(adcError), 32'h0);
    check("t4_busy_again", 32'(adcBusy), 32'h1);
    wait_ready("t4_retry");
    check("t4_retry_res", 32'(adcOutputData), 32'(res));

    // reset during step 12
    repeat (5) tick();
    base = log_q.size();
    push_reads(res);
    pulse_enable();
    wait_log(base + 13, "t5_step12");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_data",  32'(adcOutputData), 32'h0);
    check("t5_ready", 32'(adcDataReady), 32'h0);
    check("t5_busy",  32'(adcBusy), 32'h0);
    check("t5_err",   32'(adcError), 32'h0);
    check("t5_en",    32'(bus.i2cEnable), 32'h0);
    check("t5_instr", 32'(bus.i2cInstruction), 32'h0);
    check("t5_byte",  32'(bus.i2cByteToSend), 32'h0);
    check("t5_state", 32'(dbg_state), 32'h0);
    repeat (10) tick();
    rd_q.delete();
    base = log_q.size();
    push_reads(res);
    adcChannel = 2'd3;
    pulse_enable();
    wait_ready("t5_after");
    check("t5_after_res", 32'(adcOutputData), 32'(res));
    build_txn(2'd3);
    check_ops(base, 15);

    // enable dropped at step 8
    repeat (5) tick();
    base = log_q.size();
    rc = ready_cnt;
    push_reads(res);
    adcChannel = 2'd1;
    adcEnable = 1'b1;
    wait_log(base + 9, "t6_step8");
    adcEnable = 1'b0;
    wait_ready("t6");
    check("t6_res", 32'(adcOutputData), 32'(res));
    repeat (100) tick();
    check("t6_ready_once", 32'(ready_cnt), 32'(rc + 1));
    check("t6_no_restart", 32'(log_q.size()), 32'(base + 15));
    check("t6_idle", 32'(dbg_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_i2c_sequencer.md
Name: adc_i2c_sequencer

Overview:
- Transaction sequencer that sits directly upstream of the i2c byte-level engine and drives its instruction/enable/byte interface.
- Runs a complete single-shot conversion on an ADS1115-class ADC:
  - write the config register;
  - wait for the conversion;
  - point to the conversion register;
  - read two bytes.
- Presents the 16-bit result with a one-cycle ready strobe. Repeats continuously while `adcEnable` is held high.

Parameters:
- `DEV_ADDR`, `7'h48`: 7-bit I2C device address.
- `PGA`, `3'b001`: gain field placed in config bits 11:9.
- `CFG_LO`, `8'h83`: config register low byte (data rate, comparator disabled).
- `CONV_WAIT`, `16'd2000`: clk cycles to wait between config STOP and pointer START.
- `TIMEOUT`, `16'd50000`: maximum clk cycles to wait for `i2cComplete` on any one step.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `adcEnable` in 1: start or continue conversions.
- `adcChannel` in 2: single-ended input AIN0..AIN3.
- `adcOutputData` out 16: last result, {MSB, LSB}.
- `adcDataReady` out 1: one-cycle pulse when `adcOutputData` updates.
- `adcBusy` out 1: high from transaction start until DONE or abort.
- `adcError` out 1: sticky timeout flag; cleared at the next transaction start.
- `i2cInstruction` out 2: 0=START, 1=STOP, 2=READ, 3=WRITE.
- `i2cEnable` out 1: request to the i2c engine.
- `i2cByteToSend` out 8: byte for WRITE steps.
- `i2cByteReceived` in 8: byte from READ steps.
- `i2cComplete` in 1: engine step-done flag.

Behaviour:
- Reset:
  - state IDLE, step index 0;
  - all outputs 0, including `adcOutputData=16'h0000`;
  - timers cleared.
  - Reset asserted mid-transaction drops `i2cEnable` on the next edge with no STOP issued.
- States: IDLE, ISSUE, WAIT_DONE, WAIT_RELEASE, CONV_WAIT, DONE.
- IDLE, when `adcEnable=1`:
  - latch `adcChannel` into `chan`;
  - clear `adcError`, set `adcBusy`, step=0;
  - go to ISSUE.
- Channel changes after the latch are ignored until the next transaction.
- Step table (instruction / byte):
  - 0 START;
  - 1 WRITE {DEV_ADDR,0};
  - 2 WRITE 8'h01;
  - 3 WRITE cfg_hi = {1,1,chan,PGA,1};
  - 4 WRITE CFG_LO;
  - 5 STOP;
  - 6 START;
  - 7 WRITE {DEV_ADDR,0};
  - 8 WRITE 8'h00;
  - 9 STOP;
  - 10 START;
  - 11 WRITE {DEV_ADDR,1};
  - 12 READ (MSB);
  - 13 READ (LSB);
  - 14 STOP.
- Instruction and byte for non-WRITE steps: `i2cByteToSend`=8'h00.
- ISSUE (one cycle):
  - drive `i2cInstruction`/`i2cByteToSend` for the step;
  - set `i2cEnable=1`;
  - clear the timeout counter;
  - go to WAIT_DONE.
- Instruction and byte stay stable for as long as `i2cEnable` is high.
- WAIT_DONE:
  - on `i2cComplete=1`: if step is 12 or 13, capture `i2cByteReceived` into `msb`/`lsb`; set `i2cEnable=0`; go to WAIT_RELEASE.
  - otherwise increment the counter. At counter == TIMEOUT-1: set `i2cEnable=0`, set `adcError=1`, clear `adcBusy`, go to IDLE.
  - An aborted transaction leaves `adcOutputData` unchanged and issues no STOP.
- WAIT_RELEASE:
  - wait for `i2cComplete=0`;
  - then if step==5, go to CONV_WAIT; if step==14, go to DONE; else step+1 and go to ISSUE.
- CONV_WAIT:
  - count CONV_WAIT cycles;
  - then step=6 and go to ISSUE.
- DONE (one cycle):
  - `adcOutputData`<={msb,lsb};
  - `adcDataReady`=1 for exactly this cycle;
  - `adcBusy`=0;
  - go to IDLE.
- Continuous mode: if `adcEnable` is still 1 in IDLE, the next transaction starts on the following cycle. Consecutive `adcDataReady` pulses are therefore never adjacent.
- `adcEnable` falling mid-transaction: the current transaction completes normally, then the block stays in IDLE.
- `i2cComplete` already high on entry to WAIT_DONE: this counts as completion in that cycle. Engines must therefore clear `i2cComplete` before WAIT_RELEASE exits.
- No ACK checking in this block; it is the engine's responsibility.

Test Plan:
1. Engine model asserting `i2cComplete` 5 cycles after `i2cEnable` and dropping it 1 cycle after enable falls; `adcChannel=2`, one `adcEnable` pulse.
   - Instruction sequence must match steps 0-14.
   - Step 3 byte = 8'hE3.
   - READs return 8'h12 then 8'h34.
   - Requires `adcOutputData=16'h1234` with a single one-cycle `adcDataReady`.
2. Measure the gap between step-5 `i2cComplete` falling and step-6 `i2cEnable` rising: must be CONV_WAIT+2 cycles.
3. `adcEnable` held high, READ data incrementing per run:
   - three results in order;
   - ready pulses separated by at least one idle cycle;
   - `adcChannel` changed during run 1 is reflected only in run 2's cfg_hi.
4. Engine never completes step 2 (TIMEOUT=100):
   - after 100 WAIT_DONE cycles, `i2cEnable=0`, `adcError=1`, `adcBusy=0`;
   - `adcOutputData` unchanged;
   - the next start clears `adcError`.
5. `rst` pulsed during step 12:
   - next cycle all outputs are 0 and the state is IDLE;
   - a later transaction completes normally.
6. `adcEnable` dropped at step 8: the transaction completes, `adcDataReady` pulses once, and no new START is issued.
